// File: rtl/shift_add_ctrl_if.sv
// Control/status bundle between the shift-add multiplier FSM
// and its datapath (operand regs, accumulator, iteration counter).
interface shift_add_ctrl_if #(
  parameter int N  = 8,
  parameter int CW = $clog2(N+1)
);
  logic          start;
  logic          ack;
  logic          mult_lsb;
  logic          cnt_zero;
  logic          busy;
  logic          done;
  logic          ld_regs;
  logic          cnt_load;
  logic [CW-1:0] cnt_data;
  logic          cnt_en;
  logic          cnt_up_down;
  logic          acc_add;
  logic          shift_en;

  modport master (
    input  start, ack, mult_lsb, cnt_zero,
    output busy, done, ld_regs, cnt_load, cnt_data,
    output cnt_en, cnt_up_down, acc_add, shift_en
  );

  modport slave (
    output start, ack, mult_lsb, cnt_zero,
    input  busy, done, ld_regs, cnt_load, cnt_data,
    input  cnt_en, cnt_up_down, acc_add, shift_en
  );
endinterface

// File: rtl/shift_add_ctrl.sv
// Sequencing FSM for the shift-add multiplier; all outputs are
// a Moore decode of the state register.
module shift_add_ctrl #(
  parameter int N  = 8,
  parameter int CW = $clog2(N+1)
) (
  input logic            clk,
  input logic            rst,
  shift_add_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    TEST  = 3'd2,
    ADD   = 3'd3,
    SHIFT = 3'd4,
    DONE  = 3'd5
  } state_e;

  state_e state_q, state_d;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE:  state_d = bus.start ? LOAD : IDLE;
      LOAD:  state_d = TEST;
      TEST: begin
        if (bus.cnt_zero)      state_d = DONE;
        else if (bus.mult_lsb) state_d = ADD;
        else                   state_d = SHIFT;
      end
      ADD:   state_d = SHIFT;
      SHIFT: state_d = TEST;
      // start is deliberately ignored here, even alongside ack
      DONE:  state_d = bus.ack ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.busy     = 1'b0;
    bus.done     = 1'b0;
    bus.ld_regs  = 1'b0;
    bus.cnt_load = 1'b0;
    bus.cnt_en   = 1'b0;
    bus.acc_add  = 1'b0;
    bus.shift_en = 1'b0;
    case (state_q)
      LOAD: begin
        bus.busy     = 1'b1;
        bus.ld_regs  = 1'b1;
        bus.cnt_load = 1'b1;
      end
      TEST: bus.busy = 1'b1;
      ADD: begin
        bus.busy    = 1'b1;
        bus.acc_add = 1'b1;
      end
      SHIFT: begin
        bus.busy     = 1'b1;
        bus.shift_en = 1'b1;
        bus.cnt_en   = 1'b1;
      end
      DONE: begin
        bus.busy = 1'b1;
        bus.done = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.cnt_data    = CW'(N);
  assign bus.cnt_up_down = 1'b0;

endmodule

// File: tb/tb_shift_add_ctrl.sv
// Bench for shift_add_ctrl: N=8 and N=1 instances with behavioural
// counter and multiplier shift register; scoreboard of expected runs.
module tb_shift_add_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start8 = 1'b0;
  logic ack8 = 1'b0;
  logic start1 = 1'b0;
  logic ack1 = 1'b0;
  logic sel = 1'b0;
  logic [7:0] mval = 8'h00;

  always #5 clk = ~clk;

  shift_add_ctrl_if #(.N(8)) b8 ();
  shift_add_ctrl_if #(.N(1)) b1 ();

  shift_add_ctrl #(.N(8)) u8 (.clk(clk), .rst(rst), .bus(b8));
  shift_add_ctrl #(.N(1)) u1 (.clk(clk), .rst(rst), .bus(b1));

  logic [7:0] mreg8 = 8'h00;
  logic [7:0] mreg1 = 8'h00;
  logic [3:0] cnt8 = 4'd0;
  logic       cnt1 = 1'b0;

  always @(posedge clk) begin
    if (b8.ld_regs) mreg8 <= mval;
    else if (b8.shift_en) mreg8 <= mreg8 >> 1;
    if (b8.cnt_load) cnt8 <= b8.cnt_data;
    else if (b8.cnt_en)
      cnt8 <= b8.cnt_up_down ? cnt8 + 4'd1 : cnt8 - 4'd1;
    if (b1.ld_regs) mreg1 <= mval;
    else if (b1.shift_en) mreg1 <= mreg1 >> 1;
    if (b1.cnt_load) cnt1 <= b1.cnt_data;
    else if (b1.cnt_en)
      cnt1 <= b1.cnt_up_down ? cnt1 + 1'b1 : cnt1 - 1'b1;
  end

  assign b8.start    = start8;
  assign b8.ack      = ack8;
  assign b8.mult_lsb = mreg8[0];
  assign b8.cnt_zero = (cnt8 == 4'd0);
  assign b1.start    = start1;
  assign b1.ack      = ack1;
  assign b1.mult_lsb = mreg1[0];
  assign b1.cnt_zero = (cnt1 == 1'b0);

  // {busy,done,ld_regs,cnt_load,cnt_en,acc_add,shift_en}
  logic [6:0] mon8, mon1, mon;
  assign mon8 = {b8.busy, b8.done, b8.ld_regs, b8.cnt_load,
                 b8.cnt_en, b8.acc_add, b8.shift_en};
  assign mon1 = {b1.busy, b1.done, b1.ld_regs, b1.cnt_load,
                 b1.cnt_en, b1.acc_add, b1.shift_en};
  assign mon = sel ? mon1 : mon8;

  typedef struct {
    int lat;
    int adds;
    int shifts;
    int lds;
  } exp_t;

  exp_t exp_q[$];
  int n_pass = 0;
  int n_total = 0;

  task automatic run_op(input logic s, input logic [7:0] m,
                        input bit do_ack);
    exp_t e;
    int nn, lat, adds, shifts, lds, cens, ovl, nofol;
    bit seen, prev_add;
    logic [7:0] mm;
    nn = s ? 1 : 8;
    mm = s ? {7'b0, m[0]} : m;
    e.lat = 2 * nn + $countones(mm) + 2;
    e.adds = $countones(mm);
    e.shifts = nn;
    e.lds = 1;
    sel = s;
    mval = m;
    @(negedge clk);
    if (s) start1 = 1'b1; else start8 = 1'b1;
    exp_q.push_back(e);
    lat = 0; adds = 0; shifts = 0; lds = 0; cens = 0;
    ovl = 0; nofol = 0; seen = 0; prev_add = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      start1 = 1'b0;
      start8 = 1'b0;
      if (k == 0) begin
        n_total++;
        if (mon[6] !== 1'b1)
          $display("FAIL busy_rise: got %b want 1", mon[6]);
        else n_pass++;
      end
      if (mon[5] === 1'b1) begin
        seen = 1;
        lat = k;
        break;
      end
      if (mon[4]) lds++;
      if (mon[2]) cens++;
      if (mon[1]) adds++;
      if (mon[0]) shifts++;
      if (mon[1] && mon[0]) ovl++;
      if (prev_add && !mon[0]) nofol++;
      prev_add = mon[1];
    end
    if (!seen) begin
      n_total++;
      $display("FAIL done_timeout: no done within 60 cycles");
      void'(exp_q.pop_front());
      return;
    end
    n_total++;
    if (exp_q.size() == 0) begin
      $display("FAIL scoreboard: done with empty queue");
      return;
    end
    n_pass++;
    e = exp_q.pop_front();
    n_total++;
    if (lat !== e.lat)
      $display("FAIL latency m=%h: got %0d want %0d", m, lat, e.lat);
    else n_pass++;
    n_total++;
    if (adds !== e.adds)
      $display("FAIL acc_add_cnt m=%h: got %0d want %0d",
               m, adds, e.adds);
    else n_pass++;
    n_total++;
    if (shifts !== e.shifts || cens !== e.shifts)
      $display("FAIL shift_cnt m=%h: got %0d/%0d want %0d",
               m, shifts, cens, e.shifts);
    else n_pass++;
    n_total++;
    if (lds !== e.lds)
      $display("FAIL ld_regs_cnt m=%h: got %0d want %0d",
               m, lds, e.lds);
    else n_pass++;
    n_total++;
    if (ovl !== 0 || nofol !== 0)
      $display("FAIL add_shift_order m=%h: got ovl=%0d nofol=%0d want 0/0",
               m, ovl, nofol);
    else n_pass++;
    n_total++;
    if (mon[6] !== 1'b1)
      $display("FAIL busy_in_done: got %b want 1", mon[6]);
    else n_pass++;
    if (do_ack) begin
      if (s) ack1 = 1'b1; else ack8 = 1'b1;
      @(negedge clk);
      ack1 = 1'b0;
      ack8 = 1'b0;
      n_total++;
      if (mon[6:5] !== 2'b00)
        $display("FAIL ack_release: got busy,done=%b want 00", mon[6:5]);
      else n_pass++;
    end
  endtask

  task automatic test_reset();
    int bad;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    n_total++;
    if ({mon8, mon1} !== 14'b0)
      $display("FAIL reset_init: got %b want 0", {mon8, mon1});
    else n_pass++;
    n_total++;
    if (b8.cnt_data !== 4'd8 || b1.cnt_data !== 1'b1)
      $display("FAIL cnt_data: got %0d/%0d want 8/1",
               b8.cnt_data, b1.cnt_data);
    else n_pass++;
    n_total++;
    if (b8.cnt_up_down !== 1'b0 || b1.cnt_up_down !== 1'b0)
      $display("FAIL cnt_up_down: got %b%b want 00",
               b8.cnt_up_down, b1.cnt_up_down);
    else n_pass++;
    mval = 8'hA5;
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_total++;
    if (mon8 !== 7'b0)
      $display("FAIL reset_mid_op: got %b want 0", mon8);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (mon8 !== 7'b0) bad++;
    end
    n_total++;
    if (bad !== 0)
      $display("FAIL reset_stay_idle: got %0d busy cycles want 0", bad);
    else n_pass++;
  endtask

  task automatic test_patterns();
    run_op(1'b0, 8'hA5, 1'b1);
    run_op(1'b0, 8'h00, 1'b1);
    run_op(1'b0, 8'hFF, 1'b1);
  endtask

  task automatic test_handshake();
    int dn;
    run_op(1'b0, 8'h5A, 1'b0);
    dn = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (mon8[5] === 1'b1) dn++;
    end
    n_total++;
    if (dn !== 5)
      $display("FAIL done_hold: got %0d want 5", dn);
    else n_pass++;
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    n_total++;
    if (mon8 !== 7'b1100000)
      $display("FAIL start_in_done: got %b want 1100000", mon8);
    else n_pass++;
    ack8 = 1'b1;
    start8 = 1'b1;
    @(negedge clk);
    ack8 = 1'b0;
    start8 = 1'b0;
    n_total++;
    if (mon8 !== 7'b0)
      $display("FAIL ack_start_same: got %b want 0", mon8);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (mon8 !== 7'b0)
      $display("FAIL no_queued_op: got %b want 0", mon8);
    else n_pass++;
    run_op(1'b0, 8'h3C, 1'b1);
  endtask

  task automatic test_reset_in_add();
    mval = 8'h01;
    sel = 1'b0;
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (2) @(negedge clk);
    n_total++;
    if (mon8[1] !== 1'b1)
      $display("FAIL in_add: got acc_add=%b want 1", mon8[1]);
    else n_pass++;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_total++;
    if (mon8 !== 7'b0)
      $display("FAIL reset_in_add: got %b want 0", mon8);
    else n_pass++;
    run_op(1'b0, 8'h03, 1'b1);
  endtask

  task automatic test_n1();
    run_op(1'b1, 8'h01, 1'b1);
    run_op(1'b1, 8'h00, 1'b1);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++)
      run_op(1'b0, 8'($urandom_range(0, 255)), 1'b1);
  endtask

  initial begin
    test_reset();
    test_patterns();
    test_handshake();
    test_reset_in_add();
    test_n1();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
